// File: rtl/mem_image_loader.sv
// Streams host words in pairs into instruction or data memory
// while holding the core flushed; all outputs are registered.
module mem_image_loader #(
  parameter int                  DM_ADDRESS = 9,
  parameter int                  DATA_W     = 32,
  parameter int                  LEN_W      = 8,
  parameter int                  STRIDE     = 8,
  parameter logic [DM_ADDRESS-1:0] DPARK_ADDR = 9'h1F8,
  parameter logic [DM_ADDRESS-1:0] IPARK_ADDR = 9'h1F8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  target,
  input  logic [DM_ADDRESS-1:0] base_addr,
  input  logic [LEN_W-1:0]      len_words,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  enable_load_ex_mem,
  output logic [DM_ADDRESS-1:0] DataExMemAddress,
  output logic [DATA_W-1:0]     DataExMemData1,
  output logic [DATA_W-1:0]     DataExMemData2,
  output logic [DM_ADDRESS-1:0] InstExMemAddress,
  output logic [DATA_W-1:0]     InstExMemData1,
  output logic [DATA_W-1:0]     InstExMemData2,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, LO, HI, WRITE, FINISH
  } state_t;

  // wide enough to hold base + 4*len without overflow
  localparam int SUM_W = DM_ADDRESS + LEN_W + 3;

  state_t                state, state_n;
  logic                  tgt, tgt_n;
  logic [DM_ADDRESS-1:0] addr, addr_n;
  logic [LEN_W-1:0]      rem, rem_n;
  logic [DATA_W-1:0]     d1, d1_n;
  logic [DATA_W-1:0]     d2, d2_n;
  logic                  err_n;
  logic                  bad;
  logic [SUM_W-1:0]      end_addr;
  logic                  wr;
  logic                  xfer;

  assign xfer = s_valid && s_ready;

  always_comb begin
    end_addr = SUM_W'(base_addr)
             + (SUM_W'(len_words) << 2);
    bad = (len_words == '0)
       || (base_addr[2:0] != 3'd0)
       || (end_addr > (SUM_W'(1) << DM_ADDRESS));
  end

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    addr_n  = addr;
    rem_n   = rem;
    d1_n    = d1;
    d2_n    = d2;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (bad) begin
            err_n = 1'b1;
          end else begin
            tgt_n   = target;
            addr_n  = base_addr;
            rem_n   = len_words;
            state_n = LO;
          end
        end
      end
      LO: begin
        if (xfer) begin
          d1_n  = s_data;
          rem_n = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            // odd length: pad high word
            d2_n    = '0;
            state_n = WRITE;
          end else begin
            state_n = HI;
          end
        end
      end
      HI: begin
        if (xfer) begin
          d2_n    = s_data;
          rem_n   = rem - LEN_W'(1);
          state_n = WRITE;
        end
      end
      WRITE: begin
        addr_n  = addr + DM_ADDRESS'(STRIDE);
        state_n = (rem != '0) ? LO : FINISH;
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign wr = (state_n == WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      tgt                <= 1'b0;
      addr               <= '0;
      rem                <= '0;
      d1                 <= '0;
      d2                 <= '0;
      s_ready            <= 1'b0;
      enable_load_ex_mem <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      DataExMemAddress   <= DPARK_ADDR;
      DataExMemData1     <= '0;
      DataExMemData2     <= '0;
      InstExMemAddress   <= IPARK_ADDR;
      InstExMemData1     <= '0;
      InstExMemData2     <= '0;
    end else begin
      state              <= state_n;
      tgt                <= tgt_n;
      addr               <= addr_n;
      rem                <= rem_n;
      d1                 <= d1_n;
      d2                 <= d2_n;
      s_ready            <= (state_n == LO)
                         || (state_n == HI);
      enable_load_ex_mem <= (state_n != IDLE);
      busy               <= (state_n != IDLE);
      done               <= (state == FINISH);
      err                <= err_n;
      // memories write whenever enable is high,
      // so idle ports must sit on the park slot
      if (wr && tgt_n) begin
        DataExMemAddress <= addr_n;
        DataExMemData1   <= d1_n;
        DataExMemData2   <= d2_n;
      end else begin
        DataExMemAddress <= DPARK_ADDR;
        DataExMemData1   <= '0;
        DataExMemData2   <= '0;
      end
      if (wr && !tgt_n) begin
        InstExMemAddress <= addr_n;
        InstExMemData1   <= d1_n;
        InstExMemData2   <= d2_n;
      end else begin
        InstExMemAddress <= IPARK_ADDR;
        InstExMemData1   <= '0;
        InstExMemData2   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader: reset, loads,
// rejected starts, mid-session start and reset.
module tb_mem_image_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        target;
  logic [8:0]  base_addr;
  logic [7:0]  len_words;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        enable_load_ex_mem;
  logic [8:0]  DataExMemAddress;
  logic [31:0] DataExMemData1;
  logic [31:0] DataExMemData2;
  logic [8:0]  InstExMemAddress;
  logic [31:0] InstExMemData1;
  logic [31:0] InstExMemData2;
  logic        busy;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] words [8];
  logic [8:0]  wr_addr [8];
  logic [31:0] wr_d1 [8];
  logic [31:0] wr_d2 [8];
  int          nwr;
  int          accepted;
  bit          other_bad;
  bit          err_seen;
  bit          got_done;

  mem_image_loader dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .target             (target),
    .base_addr          (base_addr),
    .len_words          (len_words),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .enable_load_ex_mem (enable_load_ex_mem),
    .DataExMemAddress   (DataExMemAddress),
    .DataExMemData1     (DataExMemData1),
    .DataExMemData2     (DataExMemData2),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, "_iaddr"}, 64'(InstExMemAddress), 64'h1F8);
    chk({tag, "_daddr"}, 64'(DataExMemAddress), 64'h1F8);
    chk({tag, "_idata"},
        {InstExMemData1, InstExMemData2}, 64'h0);
    chk({tag, "_ddata"},
        {DataExMemData1, DataExMemData2}, 64'h0);
  endtask

  task automatic err_case(input string tag,
                          input logic [8:0] b,
                          input logic [7:0] l);
    target    = 1'b0;
    base_addr = b;
    len_words = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_err"}, 64'(err), 64'h1);
    chk({tag, "_en"}, 64'(enable_load_ex_mem), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk_parked(tag);
    tick();
    chk({tag, "_err_off"}, 64'(err), 64'h0);
    chk({tag, "_en2"}, 64'(enable_load_ex_mem), 64'h0);
  endtask

  // Runs one session; records writes seen on the target port.
  task automatic run_stream(input logic tgt,
                            input logic [8:0] b,
                            input int len,
                            input bit toggle,
                            input bit poke);
    bit hs;
    nwr       = 0;
    accepted  = 0;
    other_bad = 1'b0;
    err_seen  = 1'b0;
    got_done  = 1'b0;
    target    = tgt;
    base_addr = b;
    len_words = 8'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (got_done) break;
      s_valid = (accepted < len)
             && (!toggle || (cyc % 2 == 0));
      s_data  = words[accepted];
      if (poke && cyc == 3) begin
        start     = 1'b1;
        len_words = 8'd0;
        base_addr = 9'h004;
      end
      hs = s_valid && s_ready;
      tick();
      start = 1'b0;
      if (hs) accepted++;
      if (tgt) begin
        if (DataExMemAddress != 9'h1F8 && nwr < 8) begin
          wr_addr[nwr] = DataExMemAddress;
          wr_d1[nwr]   = DataExMemData1;
          wr_d2[nwr]   = DataExMemData2;
          nwr++;
        end
        if (InstExMemAddress != 9'h1F8
            || InstExMemData1 != 0
            || InstExMemData2 != 0)
          other_bad = 1'b1;
      end else begin
        if (InstExMemAddress != 9'h1F8 && nwr < 8) begin
          wr_addr[nwr] = InstExMemAddress;
          wr_d1[nwr]   = InstExMemData1;
          wr_d2[nwr]   = InstExMemData2;
          nwr++;
        end
        if (DataExMemAddress != 9'h1F8
            || DataExMemData1 != 0
            || DataExMemData2 != 0)
          other_bad = 1'b1;
      end
      if (err) err_seen = 1'b1;
      if (done) got_done = 1'b1;
    end
    s_valid = 1'b0;
    chk("stream_done_in_time", 64'(got_done), 64'h1);
    chk("stream_accepted", 64'(accepted), 64'(len));
    chk("stream_other_parked", 64'(other_bad), 64'h0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    target    = 1'b0;
    base_addr = '0;
    len_words = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    tick();
    tick();
    chk("rst_en", 64'(enable_load_ex_mem), 64'h0);
    chk("rst_rdy", 64'(s_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_pulses", {62'h0, done, err}, 64'h0);
    chk_parked("rst");
    reset = 1'b1;
    tick();
    tick();
    chk("idle_pulses", {62'h0, done, err}, 64'h0);
    chk("idle_en", 64'(enable_load_ex_mem), 64'h0);
    chk("idle_rdy", 64'(s_ready), 64'h0);

    // instruction load, len 4, back-to-back words
    target    = 1'b0;
    base_addr = 9'h000;
    len_words = 8'd4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("i_en_rise", 64'(enable_load_ex_mem), 64'h1);
    chk("i_busy", 64'(busy), 64'h1);
    chk("i_rdy_lo", 64'(s_ready), 64'h1);
    s_valid = 1'b1;
    s_data  = 32'hA000_0000;
    tick();
    chk("i_rdy_hi", 64'(s_ready), 64'h1);
    chk_parked("i_hi");
    s_data = 32'hA000_0001;
    tick();
    chk("i_w0_addr", 64'(InstExMemAddress), 64'h000);
    chk("i_w0_d1", 64'(InstExMemData1), 64'hA000_0000);
    chk("i_w0_d2", 64'(InstExMemData2), 64'hA000_0001);
    chk("i_w0_rdy", 64'(s_ready), 64'h0);
    chk("i_w0_daddr", 64'(DataExMemAddress), 64'h1F8);
    s_data = 32'hA000_0002;
    tick();
    chk_parked("i_lo2");
    chk("i_lo2_rdy", 64'(s_ready), 64'h1);
    tick();
    s_data = 32'hA000_0003;
    tick();
    chk("i_w1_addr", 64'(InstExMemAddress), 64'h008);
    chk("i_w1_d1", 64'(InstExMemData1), 64'hA000_0002);
    chk("i_w1_d2", 64'(InstExMemData2), 64'hA000_0003);
    s_valid = 1'b0;
    tick();
    chk("i_fin_en", 64'(enable_load_ex_mem), 64'h1);
    chk("i_fin_done", 64'(done), 64'h0);
    chk_parked("i_fin");
    tick();
    chk("i_done", 64'(done), 64'h1);
    chk("i_en_fall", 64'(enable_load_ex_mem), 64'h0);
    chk("i_busy_fall", 64'(busy), 64'h0);
    tick();
    chk("i_done_off", 64'(done), 64'h0);

    // odd data load with gapped valid and a stray start
    words[0] = 32'h1111_0000;
    words[1] = 32'h1111_0001;
    words[2] = 32'h1111_0002;
    run_stream(1'b1, 9'h010, 3, 1'b1, 1'b1);
    chk("d_nwr", 64'(nwr), 64'h2);
    chk("d_w0_addr", 64'(wr_addr[0]), 64'h010);
    chk("d_w0_data", {wr_d1[0], wr_d2[0]},
        {32'h1111_0000, 32'h1111_0001});
    chk("d_w1_addr", 64'(wr_addr[1]), 64'h018);
    chk("d_w1_data", {wr_d1[1], wr_d2[1]},
        {32'h1111_0002, 32'h0});
    chk("d_no_err_midsession", 64'(err_seen), 64'h0);
    tick();

    // rejected starts
    err_case("e_len0", 9'h000, 8'd0);
    err_case("e_align", 9'h004, 8'd2);
    err_case("e_range", 9'h1F0, 8'd6);

    // reset after 3 of 6 words
    target    = 1'b1;
    base_addr = 9'h040;
    len_words = 8'd6;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hC000_0000;
    tick();
    s_data = 32'hC000_0001;
    tick();
    chk("r_w0_addr", 64'(DataExMemAddress), 64'h040);
    chk("r_w0_data", {DataExMemData1, DataExMemData2},
        {32'hC000_0000, 32'hC000_0001});
    s_data = 32'hC000_0002;
    tick();
    tick();
    chk("r_mid_busy", 64'(busy), 64'h1);
    chk("r_mid_rdy", 64'(s_ready), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("r_async_en", 64'(enable_load_ex_mem), 64'h0);
    chk("r_async_rdy", 64'(s_ready), 64'h0);
    chk("r_async_busy", 64'(busy), 64'h0);
    chk_parked("r_async");
    s_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    words[0] = 32'hB000_0000;
    words[1] = 32'hB000_0001;
    run_stream(1'b0, 9'h020, 2, 1'b0, 1'b0);
    chk("r_nwr", 64'(nwr), 64'h1);
    chk("r_w_addr", 64'(wr_addr[0]), 64'h020);
    chk("r_w_data", {wr_d1[0], wr_d2[0]},
        {32'hB000_0000, 32'hB000_0001});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
